carry_chain_sequencer: RTL and testbench

//  Multi-word ALU control: replaces single-word combinational carry-in selection with a sequenced chain.

---
 rtl/alu_seq_pkg.sv | 24 ++
 rtl/cin_first_decode.sv | 39 +++
 rtl/carry_chain_sequencer.sv | 135 +++++++++++++
 tb/tb_carry_chain_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared opcodes and FSM state type for the multi-word carry-chain sequencer.
package alu_seq_pkg;

  // Arithmetic opcodes (mode = 0)
  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_ADC  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_SBB  = 3'b011;
  localparam logic [2:0] OP_INC  = 3'b100;
  localparam logic [2:0] OP_DEC  = 3'b101;
  localparam logic [2:0] OP_PASS = 3'b110;
  localparam logic [2:0] OP_NEG  = 3'b111;

  // Shift opcodes (mode = 1); 000-101 are plain logic ops in that mode
  localparam logic [2:0] OP_SHL  = 3'b110;
  localparam logic [2:0] OP_SHR  = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/cin_first_decode.sv
// Per-command carry policy: first-word carry-in, word order, chaining and flag update.
module cin_first_decode
  import alu_seq_pkg::*;
(
  input  logic [2:0] opsel_i,
  input  logic       mode_i,
  input  logic       carry_flag_i,
  output logic       first_cin_o,
  output logic       reverse_o,
  output logic       chain_en_o,
  output logic       flag_upd_o
);

  // Decode the latched operation into its carry behaviour
  always_comb begin
    first_cin_o = 1'b0;
    reverse_o   = 1'b0;
    chain_en_o  = 1'b1;
    flag_upd_o  = 1'b1;
    if (!mode_i) begin
      unique case (opsel_i)
        OP_ADD, OP_DEC, OP_PASS: first_cin_o = 1'b0;
        OP_ADC, OP_SBB:          first_cin_o = carry_flag_i;
        OP_SUB, OP_INC, OP_NEG:  first_cin_o = 1'b1;
        default:                 first_cin_o = 1'b0;
      endcase
      // PASS leaves the flag alone
      flag_upd_o = (opsel_i != OP_PASS);
    end else if (opsel_i == OP_SHL || opsel_i == OP_SHR) begin
      first_cin_o = carry_flag_i;
      reverse_o   = (opsel_i == OP_SHR);
    end else begin
      // Bitwise logic: no carry in, no carry between words, flag untouched
      chain_en_o = 1'b0;
      flag_upd_o = 1'b0;
    end
  end

endmodule

// File: rtl/carry_chain_sequencer.sv
// Sequences one multi-word ALU command over a single-word slice, chaining carries word to word.
module carry_chain_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned WORD_W    = 8,
  parameter int unsigned MAX_WORDS = 4,
  parameter int unsigned IDX_W     = $clog2(MAX_WORDS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [2:0]       cmd_opsel_i,
  input  logic             cmd_mode_i,
  input  logic [IDX_W-1:0] cmd_nwords_i,
  input  logic             flag_clr_i,
  output logic             slice_en_o,
  output logic [IDX_W-1:0] slice_idx_o,
  output logic [2:0]       slice_opsel_o,
  output logic             slice_mode_o,
  output logic             cin_final_o,
  input  logic             slice_cout_i,
  output logic             carry_flag_o,
  output logic             busy_o,
  output logic             done_o
);

  if (MAX_WORDS < 2) begin : g_bad_max_words
    $error("MAX_WORDS must be at least 2");
  end
  if (WORD_W == 0) begin : g_bad_word_w
    $error("WORD_W must be non-zero");
  end

  state_t           state_q, state_d;
  logic [2:0]       opsel_q, opsel_d;
  logic             mode_q, mode_d;
  logic [IDX_W-1:0] nwords_q, nwords_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             chain_q, chain_d;
  logic             flag_q, flag_d;

  logic             first_cin, reverse, chain_en, flag_upd;
  logic [31:0]      nwords_ext;

  assign nwords_ext = 32'(cmd_nwords_i);

  cin_first_decode u_cin_first_decode (
    .opsel_i      (opsel_q),
    .mode_i       (mode_q),
    .carry_flag_i (flag_q),
    .first_cin_o  (first_cin),
    .reverse_o    (reverse),
    .chain_en_o   (chain_en),
    .flag_upd_o   (flag_upd)
  );

  // Next-state and output decode
  always_comb begin
    state_d  = state_q;
    opsel_d  = opsel_q;
    mode_d   = mode_q;
    nwords_d = nwords_q;
    cnt_d    = cnt_q;
    chain_d  = chain_q;
    flag_d   = flag_clr_i ? 1'b0 : flag_q;

    cmd_ready_o = 1'b0;
    slice_en_o  = 1'b0;
    slice_idx_o = '0;
    cin_final_o = 1'b0;
    busy_o      = 1'b0;
    done_o      = 1'b0;

    unique case (state_q)
      IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) begin
          opsel_d  = cmd_opsel_i;
          mode_d   = cmd_mode_i;
          nwords_d = (nwords_ext >= MAX_WORDS) ? IDX_W'(MAX_WORDS - 1) : cmd_nwords_i;
          cnt_d    = '0;
          chain_d  = 1'b0;
          state_d  = RUN;
        end
      end
      RUN: begin
        busy_o      = 1'b1;
        slice_en_o  = 1'b1;
        slice_idx_o = reverse ? (nwords_q - cnt_q) : cnt_q;
        cin_final_o = (cnt_q == '0) ? first_cin : (chain_en & chain_q);
        chain_d     = slice_cout_i;
        if (cnt_q == nwords_q) begin
          // Final carry beats a coincident flag_clr
          if (flag_upd) flag_d = slice_cout_i;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + IDX_W'(1);
        end
      end
      DONE: begin
        busy_o  = 1'b1;
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      opsel_q  <= '0;
      mode_q   <= 1'b0;
      nwords_q <= '0;
      cnt_q    <= '0;
      chain_q  <= 1'b0;
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      opsel_q  <= opsel_d;
      mode_q   <= mode_d;
      nwords_q <= nwords_d;
      cnt_q    <= cnt_d;
      chain_q  <= chain_d;
      flag_q   <= flag_d;
    end
  end

  assign slice_opsel_o = opsel_q;
  assign slice_mode_o  = mode_q;
  assign carry_flag_o  = flag_q;

endmodule

// File: tb/tb_carry_chain_sequencer.sv
// Bench for carry_chain_sequencer: directed scenarios plus random traffic vs a slot-queue model.
module tb_carry_chain_sequencer;

  localparam int MAXW = 4;
  localparam int IW   = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [2:0]    cmd_opsel = '0;
  logic          cmd_mode = 1'b0;
  logic [IW-1:0] cmd_nwords = '0;
  logic          flag_clr = 1'b0;
  logic          slice_en;
  logic [IW-1:0] slice_idx;
  logic [2:0]    slice_opsel;
  logic          slice_mode;
  logic          cin_final;
  logic          slice_cout = 1'b0;
  logic          carry_flag;
  logic          busy;
  logic          done;

  int n_checks = 0;
  int n_errs   = 0;

  carry_chain_sequencer #(
    .WORD_W    (8),
    .MAX_WORDS (MAXW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cmd_valid_i   (cmd_valid),
    .cmd_ready_o   (cmd_ready),
    .cmd_opsel_i   (cmd_opsel),
    .cmd_mode_i    (cmd_mode),
    .cmd_nwords_i  (cmd_nwords),
    .flag_clr_i    (flag_clr),
    .slice_en_o    (slice_en),
    .slice_idx_o   (slice_idx),
    .slice_opsel_o (slice_opsel),
    .slice_mode_o  (slice_mode),
    .cin_final_o   (cin_final),
    .slice_cout_i  (slice_cout),
    .carry_flag_o  (carry_flag),
    .busy_o        (busy),
    .done_o        (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // First-word carry rule indexed by {mode, opsel}: 0 -> 0, 1 -> 1, 2 -> carry flag
  int rule_tbl [16] = '{0, 2, 1, 2, 1, 0, 0, 1,  0, 0, 0, 0, 0, 0, 2, 2};

  typedef struct packed {
    logic          is_done;
    logic [IW-1:0] idx;
    logic          first;
    logic          last;
  } slot_t;

  slot_t      q[$];
  logic [2:0] m_op;
  logic       m_mode;
  logic       m_flag;
  logic       m_prev;

  function automatic logic is_logic_op(logic [2:0] op, logic m);
    return m && (op < 3'd6);
  endfunction

  function automatic logic updates_flag(logic [2:0] op, logic m);
    return m ? (op >= 3'd6) : (op != 3'd6);
  endfunction

  initial begin : model_chk
    slot_t      s;
    logic       e_en, e_cin, e_done;
    logic [IW-1:0] e_idx;
    logic       c_valid, c_mode, c_clr, c_cout;
    logic [2:0] c_op;
    logic [IW-1:0] c_nw;
    int         n;
    bit         was_empty;
    m_op = '0; m_mode = 1'b0; m_flag = 1'b0; m_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q.delete();
        m_op = '0; m_mode = 1'b0; m_flag = 1'b0; m_prev = 1'b0;
      end
      e_en = 1'b0; e_cin = 1'b0; e_done = 1'b0; e_idx = '0;
      if (q.size() != 0) begin
        s = q[0];
        if (s.is_done) e_done = 1'b1;
        else begin
          e_en  = 1'b1;
          e_idx = s.idx;
          if (s.first) begin
            case (rule_tbl[{m_mode, m_op}])
              0:       e_cin = 1'b0;
              1:       e_cin = 1'b1;
              default: e_cin = m_flag;
            endcase
          end else begin
            e_cin = is_logic_op(m_op, m_mode) ? 1'b0 : m_prev;
          end
        end
      end
      chk("cmd_ready", 32'(cmd_ready), 32'(q.size() == 0));
      chk("busy", 32'(busy), 32'(q.size() != 0));
      chk("done", 32'(done), 32'(e_done));
      chk("slice_en", 32'(slice_en), 32'(e_en));
      chk("slice_idx", 32'(slice_idx), 32'(e_idx));
      chk("cin_final", 32'(cin_final), 32'(e_cin));
      chk("slice_opsel", 32'(slice_opsel), 32'(m_op));
      chk("slice_mode", 32'(slice_mode), 32'(m_mode));
      chk("carry_flag", 32'(carry_flag), 32'(m_flag));
      c_valid = cmd_valid; c_op = cmd_opsel; c_mode = cmd_mode; c_nw = cmd_nwords;
      c_clr = flag_clr; c_cout = slice_cout;
      @(posedge clk);
      if (!rst_n) begin
        q.delete();
        m_op = '0; m_mode = 1'b0; m_flag = 1'b0; m_prev = 1'b0;
      end else begin
        was_empty = (q.size() == 0);
        if (!was_empty && !q[0].is_done) begin
          if (q[0].last && updates_flag(m_op, m_mode)) m_flag = c_cout;
          else if (c_clr) m_flag = 1'b0;
          m_prev = c_cout;
        end else if (c_clr) begin
          m_flag = 1'b0;
        end
        if (!was_empty) void'(q.pop_front());
        if (was_empty && c_valid) begin
          m_op   = c_op;
          m_mode = c_mode;
          n = (int'(c_nw) >= MAXW) ? MAXW : int'(c_nw) + 1;
          for (int k = 0; k < n; k++) begin
            s.is_done = 1'b0;
            s.idx     = (c_mode && c_op == 3'd7) ? IW'(n - 1 - k) : IW'(k);
            s.first   = (k == 0);
            s.last    = (k == n - 1);
            q.push_back(s);
          end
          s = '0;
          s.is_done = 1'b1;
          q.push_back(s);
        end
      end
    end
  end

  // ---------------- directed helpers ----------------
  // Issue one command from idle; collect Cin/idx per word and the cycle done appears
  task automatic run_cmd(input logic [2:0] op, input logic m, input logic [IW-1:0] nw,
                         input logic [3:0] couts, input logic [3:0] clrs,
                         output logic [3:0] cins, output logic [7:0] idxs,
                         output int done_cyc);
    cins = '0; idxs = '0; done_cyc = -1;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_opsel = op; cmd_mode = m; cmd_nwords = nw;
    @(negedge clk);
    chk("accept_ready", 32'(cmd_ready), 1);
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      cmd_valid  = 1'b0;
      slice_cout = (c <= 4) ? couts[c-1] : 1'b0;
      flag_clr   = (c <= 4) ? clrs[c-1] : 1'b0;
      @(negedge clk);
      if (c <= 4 && slice_en) begin
        cins[c-1] = cin_final;
        idxs[2*(c-1) +: 2] = slice_idx;
      end
      if (done && done_cyc < 0) done_cyc = c;
    end
    @(posedge clk); #1;
    slice_cout = 1'b0; flag_clr = 1'b0;
  endtask

  initial begin : timeout
    #2_000_000;
    n_errs++;
    $display("FAIL timeout: got running expected finished at %0t", $time);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [3:0] cins;
    logic [7:0] idxs;
    int         dc;
    bit         seen_done;

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_slice_en", 32'(slice_en), 0);
    chk("rst_carry_flag", 32'(carry_flag), 0);
    chk("rst_done", 32'(done), 0);

    // ADD, 4 words, couts 1,1,0,1
    run_cmd(3'b000, 1'b0, 2'd3, 4'b1011, 4'b0000, cins, idxs, dc);
    chk("add_cins", 32'(cins), 32'(4'b0110));
    chk("add_idxs", 32'(idxs), 32'(8'b11_10_01_00));
    chk("add_done_cycle", dc, 5);
    chk("add_flag", 32'(carry_flag), 1);

    // ADC with flag set, one word, cout 0
    run_cmd(3'b001, 1'b0, 2'd0, 4'b0000, 4'b0000, cins, idxs, dc);
    chk("adc_cin", 32'(cins[0]), 1);
    chk("adc_done_cycle", dc, 2);
    chk("adc_flag", 32'(carry_flag), 0);

    // Set flag via ADD then SHR over 3 words, couts 0,1,1
    run_cmd(3'b000, 1'b0, 2'd0, 4'b0001, 4'b0000, cins, idxs, dc);
    chk("set_flag", 32'(carry_flag), 1);
    run_cmd(3'b111, 1'b1, 2'd2, 4'b0110, 4'b0000, cins, idxs, dc);
    chk("shr_idxs", 32'(idxs[5:0]), 32'(6'b00_01_10));
    chk("shr_cins", 32'(cins[2:0]), 32'(3'b101));
    chk("shr_flag", 32'(carry_flag), 1);

    // Logic op 011: Cin 0 every word, flag untouched
    run_cmd(3'b011, 1'b1, 2'd3, 4'b1111, 4'b0000, cins, idxs, dc);
    chk("logic_cins", 32'(cins), 0);
    chk("logic_flag", 32'(carry_flag), 1);

    // flag_clr on both words; last-word carry wins
    run_cmd(3'b000, 1'b0, 2'd1, 4'b0010, 4'b0011, cins, idxs, dc);
    chk("clr_last_flag", 32'(carry_flag), 1);

    // flag_clr while idle
    flag_clr = 1'b1;
    @(posedge clk); #1 flag_clr = 1'b0;
    chk("clr_idle_flag", 32'(carry_flag), 0);
    run_cmd(3'b000, 1'b0, 2'd0, 4'b0001, 4'b0000, cins, idxs, dc);

    // Reset while processing word 1
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_opsel = 3'b000; cmd_mode = 1'b0; cmd_nwords = 2'd3;
    @(posedge clk); #1 cmd_valid = 1'b0; slice_cout = 1'b1;
    @(posedge clk); #1;
    chk("pre_rst_idx", 32'(slice_idx), 1);
    chk("pre_rst_flag", 32'(carry_flag), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", 32'(cmd_ready), 1);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_en", 32'(slice_en), 0);
    chk("midrst_flag", 32'(carry_flag), 0);
    @(posedge clk); #1 rst_n = 1'b1; slice_cout = 1'b0;
    seen_done = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    chk("midrst_no_done", 32'(seen_done), 0);

    // cmd_valid held across a whole command; opsel changed while busy
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_opsel = 3'b000; cmd_mode = 1'b0; cmd_nwords = 2'd2;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (c == 1) cmd_opsel = 3'b010;
      @(negedge clk);
      if (c == 2) chk("held_opsel_first", 32'(slice_opsel), 0);
      if (c == 4) chk("held_done_c4", 32'(done), 1);
      if (c == 4) chk("held_ready_c4", 32'(cmd_ready), 0);
      if (c == 5) chk("held_ready_c5", 32'(cmd_ready), 1);
      if (c == 6) chk("held_en_c6", 32'(slice_en), 1);
      if (c == 6) chk("held_opsel_second", 32'(slice_opsel), 2);
    end
    @(posedge clk); #1 cmd_valid = 1'b0;
    repeat (4) @(posedge clk);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #1;
      rst_n      = ($urandom_range(0, 149) != 0);
      cmd_valid  = ($urandom_range(0, 2) != 0);
      cmd_opsel  = 3'($urandom_range(0, 7));
      cmd_mode   = 1'($urandom_range(0, 1));
      cmd_nwords = IW'($urandom_range(0, MAXW - 1));
      slice_cout = 1'($urandom_range(0, 1));
      flag_clr   = ($urandom_range(0, 7) == 0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; cmd_valid = 1'b0; flag_clr = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
